// File: rtl/ff_pkg.sv
// Shared types and constants for the Forward-Forward layer sequencer.
package ff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC_WAIT,
    NORM_WAIT,
    UPD_WAIT,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic POL_POS = 1'b0;
  localparam logic POL_NEG = 1'b1;

  function automatic logic is_wait_state(input seq_state_t s);
    return (s == MAC_WAIT) || (s == NORM_WAIT) || (s == UPD_WAIT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the sequencer WAIT states; expired flags the last allowed cycle.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_eff;

  // clr coincides with the first cycle of a WAIT state, so that cycle counts as zero.
  assign count_eff = clr ? '0 : count;
  assign expired   = en && (count_eff == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count_eff + 1'b1;
    end
  end

endmodule

// File: rtl/ff_layer_scheduler.sv
// Sequences one Forward-Forward sample through the layer stack: MAC, norm and
// (in training) weight update per layer, with a positive then a negative pass.
module ff_layer_scheduler
  import ff_pkg::*;
#(
  parameter int MAX_LAYERS     = 4,
  parameter int LAYER_LOG2     = 2,
  parameter int WADDR_WIDTH    = 20,
  parameter int LAYER_W_STRIDE = 65536,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode_train,
  input  logic [LAYER_LOG2:0]    num_layers,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic                   mac_start,
  input  logic                   mac_done,
  output logic                   norm_start,
  input  logic                   norm_done,
  output logic                   upd_start,
  input  logic                   upd_done,
  output logic [LAYER_LOG2-1:0]  layer_idx,
  output logic [WADDR_WIDTH-1:0] wbase_addr,
  output logic                   buf_sel,
  output logic                   polarity
);

  localparam logic [LAYER_LOG2:0] MAX_L = (LAYER_LOG2 + 1)'(MAX_LAYERS);

  seq_state_t            state;
  logic                  mode_q;
  logic [LAYER_LOG2:0]   nlayers_q;
  logic                  is_last;
  logic                  adv;
  logic                  cfg_bad;
  logic                  start_ok;
  logic                  wd_expired;
  logic [LAYER_LOG2-1:0] next_idx;

  function automatic logic [WADDR_WIDTH-1:0] layer_base(input logic [LAYER_LOG2-1:0] idx);
    return WADDR_WIDTH'(idx) * WADDR_WIDTH'(LAYER_W_STRIDE);
  endfunction

  assign is_last  = ({1'b0, layer_idx} == (nlayers_q - 1'b1));
  assign next_idx = layer_idx + 1'b1;
  assign cfg_bad  = (num_layers == '0) || (num_layers > MAX_L);
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign adv      = ((state == NORM_WAIT) && norm_done && !mode_q) ||
                    ((state == UPD_WAIT) && upd_done);

  // Strobes are high exactly in the first cycle of each WAIT state.
  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_start | norm_start | upd_start),
    .en      (is_wait_state(state)),
    .expired (wd_expired)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would make ordering within the block matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      nlayers_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      mac_start  <= 1'b0;
      norm_start <= 1'b0;
      upd_start  <= 1'b0;
      layer_idx  <= '0;
      wbase_addr <= '0;
      buf_sel    <= 1'b0;
      polarity   <= POL_POS;
    end else begin
      mac_start  <= 1'b0;
      norm_start <= 1'b0;
      upd_start  <= 1'b0;
      done       <= 1'b0;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start_ok) begin
        mode_q    <= mode_train;
        nlayers_q <= num_layers;
        if (cfg_bad) begin
          state    <= ERROR;
          busy     <= 1'b0;
          error    <= 1'b1;
          err_code <= ERR_CFG;
        end else begin
          state      <= MAC_WAIT;
          busy       <= 1'b1;
          error      <= 1'b0;
          err_code   <= ERR_NONE;
          layer_idx  <= '0;
          wbase_addr <= '0;
          buf_sel    <= 1'b0;
          polarity   <= POL_POS;
          mac_start  <= 1'b1;
        end
      end else if (adv) begin
        if (!is_last) begin
          state      <= MAC_WAIT;
          layer_idx  <= next_idx;
          wbase_addr <= layer_base(next_idx);
          buf_sel    <= ~buf_sel;
          mac_start  <= 1'b1;
        end else if (mode_q && (polarity == POL_POS)) begin
          state      <= MAC_WAIT;
          polarity   <= POL_NEG;
          layer_idx  <= '0;
          wbase_addr <= '0;
          buf_sel    <= 1'b0;
          mac_start  <= 1'b1;
        end else begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          MAC_WAIT: begin
            if (mac_done) begin
              state      <= NORM_WAIT;
              norm_start <= 1'b1;
            end else if (wd_expired) begin
              state    <= ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          NORM_WAIT: begin
            // Inference-mode norm_done is consumed by the layer advance above.
            if (norm_done) begin
              state     <= UPD_WAIT;
              upd_start <= 1'b1;
            end else if (wd_expired) begin
              state    <= ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          UPD_WAIT: begin
            if (wd_expired) begin
              state    <= ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
